// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory load/store unit: access sizes and
// the clear/ready controller states.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

endpackage

// File: rtl/dmem_align.sv
// Byte-lane steering for the LSU: store-side strobe/replication and error
// detection, load-side lane select with sign/zero extension.
module dmem_align
    import dmem_pkg::*;
(
    input  logic [1:0]  req_size,
    input  logic [1:0]  req_lo,
    input  logic [31:0] req_wdata,
    output logic        req_err,
    output logic [3:0]  req_be,
    output logic [31:0] req_wword,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_lo,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [31:0] ld_shift;

    always_comb begin
        req_err   = 1'b0;
        req_be    = 4'b0000;
        req_wword = '0;
        case (req_size)
            SZ_BYTE: begin
                req_be    = 4'b0001 << req_lo;
                req_wword = {4{req_wdata[7:0]}};
            end
            SZ_HALF: begin
                req_err   = req_lo[0];
                req_be    = 4'b0011 << req_lo;
                req_wword = {2{req_wdata[15:0]}};
            end
            SZ_WORD: begin
                req_err   = (req_lo != 2'b00);
                req_be    = 4'b1111;
                req_wword = req_wdata;
            end
            default: req_err = 1'b1;
        endcase
        // An erroring request must never touch the array.
        if (req_err) begin
            req_be = 4'b0000;
        end
    end

    always_comb begin
        ld_shift = ld_word >> {ld_lo, 3'b000};
        case (ld_size)
            SZ_BYTE: ld_data = {{24{~ld_unsigned & ld_shift[7]}}, ld_shift[7:0]};
            SZ_HALF: ld_data = {{16{~ld_unsigned & ld_shift[15]}}, ld_shift[15:0]};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Byte-addressable data memory with a one-cycle load/store port and a
// word-at-a-time zero-fill sequence after reset or on request.
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int ADDR_W         = 11,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_req,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int WIDX_W = ADDR_W - 2;
    localparam int DEPTH  = 1 << WIDX_W;

    state_e            state_q, state_d;
    logic [WIDX_W-1:0] clr_idx_q, clr_idx_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_load_q, rsp_load_d;
    logic              rsp_unsigned_q, rsp_unsigned_d;
    logic [1:0]        rsp_size_q, rsp_size_d;
    logic [1:0]        rsp_lo_q, rsp_lo_d;
    logic [31:0]       rd_word_q;

    logic [3:0][7:0]   mem [DEPTH];

    logic              accept;
    logic              a_err;
    logic [3:0]        a_be;
    logic [31:0]       a_wword;
    logic [31:0]       ld_data;
    logic              mem_we;
    logic [WIDX_W-1:0] mem_widx;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;

    dmem_align u_align (
        .req_size    (req_size),
        .req_lo      (req_addr[1:0]),
        .req_wdata   (req_wdata),
        .req_err     (a_err),
        .req_be      (a_be),
        .req_wword   (a_wword),
        .ld_size     (rsp_size_q),
        .ld_lo       (rsp_lo_q),
        .ld_unsigned (rsp_unsigned_q),
        .ld_word     (rd_word_q),
        .ld_data     (ld_data)
    );

    assign busy      = (state_q == ST_CLEAR);
    assign req_ready = ~busy;
    assign accept    = req_valid & req_ready;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            ST_CLEAR: begin
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == WIDX_W'(DEPTH - 1)) begin
                    state_d = ST_READY;
                end
            end
            default: begin
                // A request accepted on this edge still gets its response.
                if (clear_req) begin
                    state_d   = ST_CLEAR;
                    clr_idx_d = '0;
                end
            end
        endcase

        rsp_valid_d    = accept;
        rsp_err_d      = accept & a_err;
        rsp_load_d     = accept & ~req_we & ~a_err;
        rsp_unsigned_d = req_unsigned;
        rsp_size_d     = req_size;
        rsp_lo_d       = req_addr[1:0];

        mem_we    = busy | (accept & req_we & ~a_err);
        mem_widx  = busy ? clr_idx_q : req_addr[ADDR_W-1:2];
        mem_be    = busy ? 4'b1111 : a_be;
        mem_wdata = busy ? 32'h0 : a_wword;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
            clr_idx_q      <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_err_q      <= 1'b0;
            rsp_load_q     <= 1'b0;
            rsp_unsigned_q <= 1'b0;
            rsp_size_q     <= 2'b00;
            rsp_lo_q       <= 2'b00;
        end else begin
            state_q        <= state_d;
            clr_idx_q      <= clr_idx_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_err_q      <= rsp_err_d;
            rsp_load_q     <= rsp_load_d;
            rsp_unsigned_q <= rsp_unsigned_d;
            rsp_size_q     <= rsp_size_d;
            rsp_lo_q       <= rsp_lo_d;
        end
    end

    // Array is intentionally unreset; a store on edge N is visible to a read on edge N+1.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) begin
                    mem[mem_widx][b] <= mem_wdata[8*b +: 8];
                end
            end
        end
        rd_word_q <= mem[req_addr[ADDR_W-1:2]];
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_load_q ? ld_data : 32'h0;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed and randomized bench for dmem_lsu against a byte-array reference model.
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear_req = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [10:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int ntests = 0;
    int nfail  = 0;

    logic [7:0] mem_m [0:2047];

    dmem_lsu #(.ADDR_W(11), .CLEAR_ON_RESET(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .clear_req    (clear_req),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic m_err(input logic [1:0] sz, input logic [10:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns, input logic [10:0] a);
        logic [31:0] v = '0;
        int n = 1 << sz;
        for (int i = 0; i < n; i++) begin
            v = v | (32'(mem_m[a + 11'(i)]) << (8 * i));
        end
        if (sz == 2'd0 && !uns && v[7])  v = v | 32'hFFFF_FF00;
        if (sz == 2'd1 && !uns && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic m_store(input logic [1:0] sz, input logic [10:0] a, input logic [31:0] d);
        int n = 1 << sz;
        for (int i = 0; i < n; i++) begin
            mem_m[a + 11'(i)] = d[8*i +: 8];
        end
    endtask

    task automatic m_clear();
        for (int i = 0; i < 2048; i++) mem_m[i] = 8'h00;
    endtask

    // One accepted request; the response is checked one cycle later.
    task automatic send(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [10:0] a, input logic [31:0] wd, input logic clr);
        logic        e;
        logic [31:0] exp;
        chk({tag, ".ready"}, req_ready, 1);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd; clear_req = clr;
        e   = m_err(sz, a);
        exp = (we || e) ? 32'h0 : m_load(sz, uns, a);
        if (we && !e) m_store(sz, a, wd);
        step();
        req_valid = 1'b0;
        clear_req = 1'b0;
        chk({tag, ".valid"}, rsp_valid, 1);
        chk({tag, ".err"}, rsp_err, e);
        chk({tag, ".rdata"}, rsp_rdata, exp);
    endtask

    task automatic idle(input string tag);
        req_valid = 1'b0;
        step();
        chk({tag, ".idle_valid"}, rsp_valid, 0);
    endtask

    // Counts busy samples starting at the current one; optionally pulses clear_req mid-fill.
    task automatic measure_busy(input string tag, input int clr_at);
        int   cnt = 0;
        logic bad_ready = 1'b0;
        logic bad_valid = 1'b0;
        while (busy === 1'b1 && cnt < 600) begin
            if (req_ready !== 1'b0) bad_ready = 1'b1;
            cnt++;
            if (cnt == clr_at) clear_req = 1'b1;
            step();
            clear_req = 1'b0;
            if (busy === 1'b1 && rsp_valid !== 1'b0) bad_valid = 1'b1;
        end
        chk({tag, ".busy_cycles"}, cnt, 512);
        chk({tag, ".ready_low"}, bad_ready, 0);
        chk({tag, ".no_rsp_in_clear"}, bad_valid, 0);
        m_clear();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".rst_valid"}, rsp_valid, 0);
        chk({tag, ".rst_err"}, rsp_err, 0);
        chk({tag, ".rst_rdata"}, rsp_rdata, 0);
        chk({tag, ".rst_busy"}, busy, 1);
        chk({tag, ".rst_ready"}, req_ready, 0);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem_m[i] = 8'hxx;

        // Power-on reset and initial fill
        step(); step();
        chk_reset_outputs("por");
        rst = 1'b0;
        measure_busy("por", -1);
        send("lw_7fc_zero", 1'b0, 2'd2, 1'b0, 11'h7FC, 32'h0, 1'b0);

        // Sub-word stores and extension
        send("sw_7fc", 1'b1, 2'd2, 1'b0, 11'h7FC, 32'h1122_3344, 1'b0);
        send("sb_7fd", 1'b1, 2'd0, 1'b0, 11'h7FD, 32'h0000_00AA, 1'b0);
        send("sh_7fe", 1'b1, 2'd1, 1'b0, 11'h7FE, 32'h0000_8001, 1'b0);
        send("lw_7fc", 1'b0, 2'd2, 1'b0, 11'h7FC, 32'h0, 1'b0);
        chk("lw_7fc.const", rsp_rdata, 32'h8001_AA44);
        send("lh_7fe", 1'b0, 2'd1, 1'b0, 11'h7FE, 32'h0, 1'b0);
        chk("lh_7fe.const", rsp_rdata, 32'hFFFF_8001);
        send("lhu_7fe", 1'b0, 2'd1, 1'b1, 11'h7FE, 32'h0, 1'b0);
        chk("lhu_7fe.const", rsp_rdata, 32'h0000_8001);
        send("lb_7fd", 1'b0, 2'd0, 1'b0, 11'h7FD, 32'h0, 1'b0);
        chk("lb_7fd.const", rsp_rdata, 32'hFFFF_FFAA);
        send("lbu_7fd", 1'b0, 2'd0, 1'b1, 11'h7FD, 32'h0, 1'b0);

        // Misalignment and illegal size
        send("sw_000", 1'b1, 2'd2, 1'b0, 11'h000, 32'h55AA_1234, 1'b0);
        send("sw_002_mis", 1'b1, 2'd2, 1'b0, 11'h002, 32'hFFFF_FFFF, 1'b0);
        send("lh_001_mis", 1'b0, 2'd1, 1'b0, 11'h001, 32'h0, 1'b0);
        send("s_ill_000", 1'b1, 2'd3, 1'b0, 11'h000, 32'h0BAD_0BAD, 1'b0);
        send("l_ill_000", 1'b0, 2'd3, 1'b0, 11'h000, 32'h0, 1'b0);
        send("lw_000_kept", 1'b0, 2'd2, 1'b0, 11'h000, 32'h0, 1'b0);
        chk("lw_000_kept.const", rsp_rdata, 32'h55AA_1234);

        // Back-to-back store then load
        idle("gap");
        send("sw_010", 1'b1, 2'd2, 1'b0, 11'h010, 32'hDEAD_BEEF, 1'b0);
        send("lw_010", 1'b0, 2'd2, 1'b0, 11'h010, 32'h0, 1'b0);
        chk("lw_010.const", rsp_rdata, 32'hDEAD_BEEF);

        // Randomized traffic
        for (int it = 0; it < 300; it++) begin
            logic [1:0]  sz;
            logic [10:0] a;
            if ($urandom_range(0, 9) == 0) begin
                idle("rnd");
            end else begin
                sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                a  = ($urandom_range(0, 1) == 1) ? 11'($urandom_range(0, 63)) : 11'($urandom);
                if (sz != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~11'((1 << sz) - 1);
                send("rnd", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, 1'b0);
            end
        end

        // Clear coinciding with an accepted load; a second clear_req mid-fill is ignored
        send("sw_020", 1'b1, 2'd2, 1'b0, 11'h020, 32'h1357_9BDF, 1'b0);
        send("lw_020_clr", 1'b0, 2'd2, 1'b0, 11'h020, 32'h0, 1'b1);
        chk("lw_020_clr.const", rsp_rdata, 32'h1357_9BDF);
        chk("clr_entry_busy", busy, 1);
        measure_busy("clr", 200);
        for (int w = 0; w < 512; w++) begin
            send("sweep", 1'b0, 2'd2, 1'b0, 11'(w * 4), 32'h0, 1'b0);
        end

        // Reset while a load response is on the outputs
        send("sw_100", 1'b1, 2'd2, 1'b0, 11'h100, 32'hCAFE_F00D, 1'b0);
        send("lw_100", 1'b0, 2'd2, 1'b0, 11'h100, 32'h0, 1'b0);
        rst = 1'b1;
        #1;
        chk_reset_outputs("rst_rsp");
        step(); step();
        rst = 1'b0;
        measure_busy("rst_rsp", -1);
        send("lw_100_zero", 1'b0, 2'd2, 1'b0, 11'h100, 32'h0, 1'b0);

        // Reset at clear cycle 100 restarts the full fill
        send("sw_7f0", 1'b1, 2'd2, 1'b0, 11'h7F0, 32'hA5A5_5A5A, 1'b0);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        for (int c = 1; c < 100; c++) step();
        chk("mid_clear_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk_reset_outputs("mid_clear");
        step(); step();
        rst = 1'b0;
        measure_busy("mid_clear", -1);
        send("lw_7f0_zero", 1'b0, 2'd2, 1'b0, 11'h7F0, 32'h0, 1'b0);
        send("lw_7fc_end", 1'b0, 2'd2, 1'b0, 11'h7FC, 32'h0, 1'b0);
        idle("end");

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
